// File: rtl/fp64_pkg.sv
// Shared constants and types for the binary64 divider.
package fp64_pkg;

  localparam int SIGN_W     = 1;
  localparam int EXP_W      = 11;
  localparam int FRAC_W     = 52;
  localparam int SIG_W      = FRAC_W + 1;   // significand including hidden bit
  localparam int QUO_W      = 56;           // quotient bits 2^0 .. 2^-55
  localparam int EXP_CALC_W = 13;           // signed working exponent

  localparam int EXP_BIAS = 1023;
  localparam int EXP_MAX  = 2047;

  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] POS_INF = 64'h7FF0_0000_0000_0000;

  typedef enum logic [2:0] {IDLE, CALC, NORM, ROUND, DONE} state_t;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic div_by_zero;
    logic invalid;
  } flags_t;

endpackage

// File: rtl/fp64_divider_if.sv
// Request/response bundle between a requester and the binary64 divider.
interface fp64_divider_if;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  modport master (
    output start, A, B,
    input  busy, done, quotient, overflow, underflow, div_by_zero, invalid
  );

  modport slave (
    input  start, A, B,
    output busy, done, quotient, overflow, underflow, div_by_zero, invalid
  );
endinterface

// File: rtl/fp64_classify.sv
// Splits one binary64 operand into fields and classifies it.
// Subnormals are flushed to a signed zero.
module fp64_classify
  import fp64_pkg::*;
(
  input  logic [63:0]      i_op,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp,
  output logic [SIG_W-1:0] o_sig,
  output fp_class_t        o_cls
);

  // Field extraction and class decode
  always_comb begin
    // NOTE: every output gets a default before the if/else chain so no branch
    // can leave one unassigned, which would otherwise infer a latch.
    o_sign = i_op[63];
    o_exp  = i_op[62:52];
    o_sig  = {1'b1, i_op[51:0]};
    o_cls  = NORMAL;
    if (i_op[62:52] == '0) begin
      o_cls = ZERO;
      o_exp = '0;
      o_sig = '0;
    end else if (i_op[62:52] == '1) begin
      o_cls = (i_op[51:0] != '0) ? NAN : INF;
    end
  end

endmodule

// File: rtl/fp64_divider.sv
// Multi-cycle binary64 divider: restoring division, one quotient bit per
// cycle, round-to-nearest-even, flush-to-zero on both inputs and outputs.
module fp64_divider
  import fp64_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp64_divider_if.slave bus
);

  localparam logic signed [EXP_CALC_W-1:0] E_MAX_S = EXP_CALC_W'(EXP_MAX);

  logic             w_sign_a, w_sign_b;
  logic [EXP_W-1:0] w_exp_a, w_exp_b;
  logic [SIG_W-1:0] w_sig_a, w_sig_b;
  fp_class_t        w_cls_a, w_cls_b;

  fp64_classify u_cls_a (
    .i_op(bus.A), .o_sign(w_sign_a), .o_exp(w_exp_a), .o_sig(w_sig_a), .o_cls(w_cls_a)
  );
  fp64_classify u_cls_b (
    .i_op(bus.B), .o_sign(w_sign_b), .o_exp(w_exp_b), .o_sig(w_sig_b), .o_cls(w_cls_b)
  );

  state_t                        r_state;
  logic                          r_busy, r_done;
  logic [63:0]                   r_q, r_res;
  flags_t                        r_flags, r_res_flags;
  logic                          r_sign;
  logic signed [EXP_CALC_W-1:0]  r_exp;
  logic [SIG_W:0]                r_rem;
  logic [SIG_W-1:0]              r_div;
  logic [QUO_W-1:0]              r_quo;
  logic [5:0]                    r_cnt;

  logic                          w_sign;
  logic                          w_special;
  logic [63:0]                   w_spec_res;
  flags_t                        w_spec_flags;
  logic signed [EXP_CALC_W-1:0]  w_exp_init;

  assign w_sign     = w_sign_a ^ w_sign_b;
  assign w_exp_init = EXP_CALC_W'({2'b00, w_exp_a}) - EXP_CALC_W'({2'b00, w_exp_b})
                    + EXP_CALC_W'(EXP_BIAS);

  // Special-operand result, resolved at accept time in priority order
  always_comb begin
    w_special    = 1'b1;
    w_spec_res   = '0;
    w_spec_flags = '0;
    if (w_cls_a == NAN || w_cls_b == NAN) begin
      w_spec_res           = QNAN;
      w_spec_flags.invalid = 1'b1;
    end else if ((w_cls_a == ZERO && w_cls_b == ZERO) || (w_cls_a == INF && w_cls_b == INF)) begin
      w_spec_res           = QNAN;
      w_spec_flags.invalid = 1'b1;
    end else if (w_cls_a == INF) begin
      w_spec_res = {w_sign, POS_INF[62:0]};
    end else if (w_cls_b == INF) begin
      w_spec_res = {w_sign, 63'd0};
    end else if (w_cls_b == ZERO) begin
      w_spec_res               = {w_sign, POS_INF[62:0]};
      w_spec_flags.div_by_zero = 1'b1;
    end else if (w_cls_a == ZERO) begin
      w_spec_res = {w_sign, 63'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  logic             w_ge;
  logic [SIG_W-1:0] w_rem_sub;

  // One restoring-division step: subtract the divisor when it fits
  always_comb begin
    w_ge      = r_rem >= {1'b0, r_div};
    w_rem_sub = w_ge ? SIG_W'(r_rem - {1'b0, r_div}) : r_rem[SIG_W-1:0];
  end

  logic                         w_guard, w_sticky, w_up, w_carry;
  logic [FRAC_W-1:0]            w_frac_rnd;
  logic signed [EXP_CALC_W-1:0] w_exp_rnd;
  logic [63:0]                  w_rnd_res;
  flags_t                       w_rnd_flags;

  // Round-to-nearest-even on the normalised quotient, then range check.
  // Kept bits are r_quo[55:3]; r_quo[55] is the hidden bit.
  always_comb begin
    w_guard                = r_quo[2];
    w_sticky               = (|r_quo[1:0]) | (|r_rem);
    w_up                   = w_guard & (w_sticky | r_quo[3]);
    {w_carry, w_frac_rnd}  = {1'b0, r_quo[54:3]} + (FRAC_W + 1)'(w_up);
    w_exp_rnd              = w_carry ? r_exp + 13'sd1 : r_exp;
    w_rnd_res              = '0;
    w_rnd_flags            = '0;
    if (w_exp_rnd >= E_MAX_S) begin
      w_rnd_res            = {r_sign, POS_INF[62:0]};
      w_rnd_flags.overflow = 1'b1;
    end else if (w_exp_rnd <= 13'sd0) begin
      w_rnd_res             = {r_sign, 63'd0};
      w_rnd_flags.underflow = 1'b1;
    end else begin
      w_rnd_res = {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    // NOTE: the synchronous reset clears every datapath register, not just
    // the FSM, so an aborted operation leaves nothing behind for the next one.
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_q         <= '0;
      r_res       <= '0;
      r_flags     <= '0;
      r_res_flags <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block samples the pre-edge values regardless of statement order.
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (r_busy) begin
            r_busy <= 1'b0;             // the done-pulse cycle is the last busy cycle
          end else if (bus.start) begin
            r_busy  <= 1'b1;
            r_q     <= '0;
            r_flags <= '0;
            r_sign  <= w_sign;
            if (w_special) begin
              r_res       <= w_spec_res;
              r_res_flags <= w_spec_flags;
              r_state     <= DONE;
            end else begin
              r_rem   <= {1'b0, w_sig_a};
              r_div   <= w_sig_b;
              r_quo   <= '0;
              r_cnt   <= '0;
              r_exp   <= w_exp_init;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= {w_rem_sub, 1'b0};
          r_quo <= {r_quo[QUO_W-2:0], w_ge};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(QUO_W - 1)) r_state <= NORM;
        end
        NORM: begin
          if (!r_quo[QUO_W-1]) begin
            r_quo <= {r_quo[QUO_W-2:0], 1'b0};
            r_exp <= r_exp - 13'sd1;
          end
          r_state <= ROUND;
        end
        ROUND: begin
          r_res       <= w_rnd_res;
          r_res_flags <= w_rnd_flags;
          r_state     <= DONE;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_q     <= r_res;
          r_flags <= r_res_flags;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_q;
  assign bus.overflow    = r_flags.overflow;
  assign bus.underflow   = r_flags.underflow;
  assign bus.div_by_zero = r_flags.div_by_zero;
  assign bus.invalid     = r_flags.invalid;

endmodule

// File: tb/tb_fp64_divider.sv
// Scoreboard bench for fp64_divider: a real-arithmetic reference model
// predicts each result, a monitor checks it when done pulses.
module tb_fp64_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp64_divider_if bus();

  fp64_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] q;
    logic [3:0]  f;      // {overflow, underflow, div_by_zero, invalid}
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   n_done   = 0;
  int   n_issued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference: IEEE double division in the simulator, wrapped with the
  // flush-to-zero and special-case rules of the divider.
  function automatic void model(input logic [63:0] a_in, input logic [63:0] b_in,
                                output logic [63:0] q, output logic [3:0] f,
                                output bit special);
    logic [63:0] a, b, rb;
    logic        s;
    bit          na, nb, ia, ib, za, zb;
    real         r;
    a = a_in;
    b = b_in;
    if (a[62:52] == 11'd0) a = {a[63], 63'd0};
    if (b[62:52] == 11'd0) b = {b[63], 63'd0};
    s  = a[63] ^ b[63];
    na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    ia = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
    ib = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
    za = (a[62:0] == 63'd0);
    zb = (b[62:0] == 63'd0);
    special = 1'b1;
    f = 4'b0000;
    if (na || nb)                   begin q = 64'h7FF8000000000000; f = 4'b0001; end
    else if ((za && zb) || (ia && ib)) begin q = 64'h7FF8000000000000; f = 4'b0001; end
    else if (ia)                    q = {s, 63'h7FF0000000000000};
    else if (ib)                    q = {s, 63'd0};
    else if (zb)                    begin q = {s, 63'h7FF0000000000000}; f = 4'b0010; end
    else if (za)                    q = {s, 63'd0};
    else begin
      special = 1'b0;
      r  = $bitstoreal(a) / $bitstoreal(b);
      rb = $realtobits(r);
      if (rb[62:52] == 11'h7FF)     begin q = {s, 63'h7FF0000000000000}; f = 4'b1000; end
      else if (rb[62:52] == 11'd0)  begin q = {s, 63'd0}; f = 4'b0100; end
      else                          q = rb;
    end
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit push);
    logic [63:0] q;
    logic [3:0]  f;
    bit          sp;
    int          t;
    exp_t        e;
    model(a, b, q, f, sp);
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: busy still %b after %0d cycles", bus.busy, t);
    end
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    if (push) begin
      e.q   = q;
      e.f   = f;
      e.lat = sp ? 1 : 59;
      e.acc = cyc;
      sb.push_back(e);
      n_issued++;
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got quotient %h expected no result", bus.quotient);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("flags", {60'd0, bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid},
              {60'd0, e.f});
        check("latency", 64'(cyc - e.acc), 64'(e.lat));
        check("busy_at_done", {63'd0, bus.busy}, 64'd1);
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd_normal();
    logic [63:0] v;
    v[63]    = 1'($urandom);
    v[62:52] = 11'($urandom_range(1150, 900));
    v[51:20] = $urandom;
    v[19:0]  = 20'($urandom);
    return v;
  endfunction

  logic [63:0] da [14] = '{
    64'h4018000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000,
    64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000,
    64'h7FEFFFFFFFFFFFFF, 64'h0010000000000000, 64'h7FF0000000000001,
    64'hFFF0000000000000, 64'h4000000000000000, 64'h8000000000000001,
    64'h3FF0000000000000, 64'h0000000000000000};
  logic [63:0] db [14] = '{
    64'h4000000000000000, 64'h4008000000000000, 64'h4000000000000000,
    64'h0000000000000000, 64'h0000000000000000, 64'h7FF0000000000000,
    64'h3FE0000000000000, 64'h4000000000000000, 64'h3FF0000000000000,
    64'h4000000000000000, 64'h7FF0000000000000, 64'h3FF0000000000000,
    64'h000FFFFFFFFFFFFF, 64'h4000000000000000};

  initial begin
    int done_before;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_quotient", bus.quotient, 64'd0);
    check("reset_flags", {60'd0, bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid}, 64'd0);
    rst = 1'b0;

    // Directed operand pairs
    for (int i = 0; i < 14; i++) issue(da[i], db[i], 1'b1);
    drain();

    // A second start during an operation must be ignored
    issue(64'h4018000000000000, 64'h4000000000000000, 1'b1);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 64'h3FF0000000000000;
    bus.B     = 64'h4008000000000000;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    check("ignored_start_done_count", 64'(n_done), 64'(n_issued));

    // Reset in the middle of CALC aborts without a done pulse
    issue(64'h3FF0000000000000, 64'h4008000000000000, 1'b0);
    done_before = n_done;
    repeat (20) @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;                 // dropped: sampled together with rst
    @(posedge clk);
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_quotient", bus.quotient, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (80) @(negedge clk);
    check("abort_no_done", 64'(n_done), 64'(done_before));
    check("abort_idle", {63'd0, bus.busy}, 64'd0);
    issue(64'h4018000000000000, 64'h4000000000000000, 1'b1);
    drain();

    // Randomised operands: mostly in-range normals, then unconstrained bits
    for (int i = 0; i < 150; i++) issue(rnd_normal(), rnd_normal(), 1'b1);
    for (int i = 0; i < 40; i++) issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    drain();
    repeat (5) @(negedge clk);
    check("total_done_count", 64'(n_done), 64'(n_issued));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp64_divider.md
FP64_DIVIDER -- requirements
Module: fp64_divider

Interface
REQ-001 Parameters: none; all widths are fixed to IEEE-754 binary64 (1 sign, 11 exponent, 52 fraction bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 A  input  64  dividend, binary64.
REQ-006 B  input  64  divisor, binary64.
REQ-007 busy  output  1  high from the cycle after accept until the cycle done is high, inclusive.
REQ-008 done  output  1  one-cycle pulse; quotient and flags valid.
REQ-009 quotient  output  64  A/B, binary64; held until next accept.
REQ-010 overflow, underflow, div_by_zero, invalid  output  1 each  exception flags; valid and held alongside quotient.

Function
REQ-011 Accept: start=1 and busy=0 at a rising edge; A and B are registered; start while busy=1 is ignored.
REQ-012 FSM states: IDLE, CALC, NORM, ROUND, DONE; IDLE->CALC on accept (normal operands), IDLE->DONE on accept (special operands), CALC->NORM after 56 iterations, NORM->ROUND->DONE, DONE->IDLE unconditionally.
REQ-013 Latency: done high exactly 59 cycles after the accept edge for normal operands, 1 cycle for special operands; back-to-back start is accepted in the IDLE cycle following DONE.
REQ-014 Subnormal inputs are flushed to signed zero before classification.
REQ-015 Sign of every non-NaN result = A[63] XOR B[63].
REQ-016 Specials, highest priority first: either NaN -> 7FF8000000000000, invalid; 0/0 or Inf/Inf -> 7FF8000000000000, invalid; Inf/finite -> signed Inf; finite/Inf -> signed zero; nonzero finite/0 -> signed Inf, div_by_zero; 0/nonzero -> signed zero.
REQ-017 Normal path: significands with hidden bit, restoring division, one quotient bit per CALC cycle, 56 bits (2^0 down to 2^-55); sticky = final remainder nonzero.
REQ-018 Exponent: signed 13-bit, e = Ea - Eb + 1023; NORM shifts quotient left by 1 and decrements e when the 2^0 bit is 0.
REQ-019 ROUND: round-to-nearest-even on 53 kept bits using guard and sticky; mantissa carry-out renormalises and increments e.
REQ-020 e >= 2047 after rounding -> signed Inf, overflow; e <= 0 -> signed zero, underflow (no subnormal outputs).
REQ-021 Flags not listed for a case are 0; all flags cleared on accept.

Reset
REQ-022 rst=1 at any edge: state IDLE, busy=0, done=0, quotient=0, all flags 0, datapath registers cleared.
REQ-023 rst during CALC/NORM/ROUND aborts the operation; no done pulse is produced for it; a start sampled in the same cycle as rst is dropped.

Structure
REQ-024 Package fp64_pkg holds: field widths, EXP_BIAS=1023, EXP_MAX=2047, QNAN=7FF8000000000000, POS_INF=7FF0000000000000, the FSM state enum, and the operand-class enum (ZERO, NORMAL, INF, NAN).
REQ-025 One combinational sub-module fp64_classify (one instance per operand) returns sign, exponent, significand with hidden bit, and class; the FSM, divider, and rounding stay in fp64_divider.

Verification
REQ-026 A=4018000000000000 (6.0), B=4000000000000000 -> quotient 4008000000000000, flags 0, done exactly 59 cycles after accept.
REQ-027 A=3FF0000000000000, B=4008000000000000 (1/3) -> 3FD5555555555555 (RNE); A=BFF0000000000000, B=4000000000000000 -> BFE0000000000000.
REQ-028 A=3FF0000000000000, B=0 -> 7FF0000000000000, div_by_zero=1, done 1 cycle after accept; A=0, B=0 and A=B=7FF0000000000000 -> 7FF8000000000000, invalid=1.
REQ-029 A=7FEFFFFFFFFFFFFF, B=3FE0000000000000 -> 7FF0000000000000, overflow=1; A=0010000000000000, B=4000000000000000 -> 0000000000000000, underflow=1.
REQ-030 start pulsed at cycle 10 of an operation -> ignored, first result correct; rst at cycle 20 of CALC -> busy=0 next cycle, no done; a subsequent 6.0/2.0 request returns 4008000000000000.
